vecfn_stream_engine: RTL and testbench



---
 rtl/vecfn_stream_engine.sv | 96 +++++++++
 tb/tb_vecfn_stream_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vecfn_stream_engine.sv
// vecfn_stream_engine: loads a vector, streams it through an external pipelined function unit, buffers the results.
// Ports:
//   i_clk, i_rst_n                : clock, asynchronous active-low reset
//   i_in_valid/o_in_ready/i_in_data/i_in_last : operand load stream (accepted in LOAD)
//   i_read_addr, o_res            : combinational result buffer read, 0 beyond o_count
//   o_out_valid, i_done_ack       : results complete / release back to LOAD
//   o_busy, o_count               : run in progress / number of valid results
//   o_fu_ce, o_fu_in, i_fu_out    : external function unit (enable, operand, result)
module vecfn_stream_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int LATENCY = 30,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WIDTH-1:0]  i_in_data,
  input  logic              i_in_last,
  input  logic [ADDR_W-1:0] i_read_addr,
  output logic [WIDTH-1:0]  o_res,
  output logic              o_out_valid,
  input  logic              i_done_ack,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_count,
  output logic              o_fu_ce,
  output logic [WIDTH-1:0]  o_fu_in,
  input  logic [WIDTH-1:0]  i_fu_out
);
  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_op_mem [DEPTH];
  logic [WIDTH-1:0] r_res_mem [DEPTH];
  logic [ADDR_W-1:0] r_load_idx, r_issue_idx;
  logic [ADDR_W:0] r_len, r_wr_idx;
  logic [LATENCY-1:0] r_dly, w_dly_nx;
  logic w_accept, w_load_end, w_issue_end, w_capture, w_capture_end;
  assign w_accept = i_in_valid && r_state == S_LOAD;
  assign w_load_end = w_accept && (i_in_last || r_load_idx == ADDR_W'(DEPTH - 1));
  assign w_issue_end = r_state == S_ISSUE && {1'b0, r_issue_idx} == r_len - 1'b1;
  // the delay line's output bit marks the enabled cycle in which fu_out holds a live result
  assign w_capture = r_dly[LATENCY-1] && o_fu_ce;
  assign w_capture_end = w_capture && r_wr_idx + 1'b1 == r_len;
  // a 1 enters the delay line for every issued operand, 0 while draining
  if (LATENCY == 1) begin : g_dly1
    assign w_dly_nx = r_state == S_ISSUE;
  end else begin : g_dlyn
    assign w_dly_nx = {r_dly[LATENCY-2:0], r_state == S_ISSUE};
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_LOAD;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  w_next = w_load_end ? S_ISSUE : S_LOAD;
      S_ISSUE: w_next = w_issue_end ? S_DRAIN : S_ISSUE;
      S_DRAIN: w_next = w_capture_end ? S_DONE : S_DRAIN;
      S_DONE:  w_next = i_done_ack ? S_LOAD : S_DONE;
      default: w_next = S_LOAD;
    endcase
  end
  always_comb begin
    o_in_ready = r_state == S_LOAD;
    o_out_valid = r_state == S_DONE;
    o_busy = r_state != S_LOAD;
    o_fu_ce = r_state == S_ISSUE || r_state == S_DRAIN;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_load_idx <= '0;
      r_issue_idx <= '0;
      r_len <= '0;
      r_wr_idx <= '0;
      r_dly <= '0;
    end else begin
      if (w_accept) r_load_idx <= w_load_end ? '0 : r_load_idx + 1'b1;
      if (w_load_end) r_len <= {1'b0, r_load_idx} + 1'b1;
      // issue_idx parks on the last operand so DRAIN keeps presenting it
      if (r_state == S_ISSUE && !w_issue_end) r_issue_idx <= r_issue_idx + 1'b1;
      if (o_fu_ce) r_dly <= w_dly_nx;
      if (w_capture) r_wr_idx <= r_wr_idx + 1'b1;
      if (r_state == S_DONE && i_done_ack) begin
        r_wr_idx <= '0;
        r_issue_idx <= '0;
      end
    end
  always_ff @(posedge i_clk) begin
    if (w_accept) r_op_mem[r_load_idx] <= i_in_data;
    if (w_capture) r_res_mem[r_wr_idx[ADDR_W-1:0]] <= i_fu_out;
  end
  assign o_count = r_wr_idx;
  assign o_fu_in = r_op_mem[r_issue_idx];
  assign o_res = {1'b0, i_read_addr} < r_wr_idx ? r_res_mem[i_read_addr] : '0;
endmodule

// File: tb/tb_vecfn_stream_engine.sv
// tb_vecfn_stream_engine: self-checking bench for vecfn_stream_engine (default build plus a LATENCY=1 build).
module tb_vecfn_stream_engine;
  logic clk = 0;
  logic rst_n;
  logic in_valid, in_ready, in_last, out_valid, done_ack, busy, fu_ce;
  logic [31:0] in_data, res, fu_in, fu_out;
  logic [4:0] read_addr;
  logic [5:0] count;
  logic in_valid2, in_ready2, in_last2, out_valid2, done_ack2, busy2, fu_ce2;
  logic [31:0] in_data2, res2, fu_in2, fu_out2;
  logic [1:0] read_addr2;
  logic [2:0] count2;
  int total = 0, bad = 0;
  logic [31:0] ops [32];
  logic [31:0] pipe1 [30];
  logic [31:0] pipe2;
  typedef struct {
    int len;
    logic [31:0] base;
    bit use_last;
    bit noise;
    int exp_lat;
    logic [31:0] exp_first;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  vecfn_stream_engine dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_last(in_last), .i_read_addr(read_addr), .o_res(res),
    .o_out_valid(out_valid), .i_done_ack(done_ack), .o_busy(busy), .o_count(count),
    .o_fu_ce(fu_ce), .o_fu_in(fu_in), .i_fu_out(fu_out)
  );

  vecfn_stream_engine #(.WIDTH(32), .DEPTH(4), .LATENCY(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid2), .o_in_ready(in_ready2),
    .i_in_data(in_data2), .i_in_last(in_last2), .i_read_addr(read_addr2), .o_res(res2),
    .o_out_valid(out_valid2), .i_done_ack(done_ack2), .o_busy(busy2), .o_count(count2),
    .o_fu_ce(fu_ce2), .o_fu_in(fu_in2), .i_fu_out(fu_out2)
  );

  // external function units: result = operand + 1, delivered LATENCY enabled cycles later
  always @(posedge clk)
    if (fu_ce) begin
      pipe1[0] <= fu_in + 32'd1;
      for (int i = 1; i < 30; i++) pipe1[i] <= pipe1[i-1];
    end
  assign fu_out = pipe1[29];
  always @(posedge clk)
    if (fu_ce2) pipe2 <= fu_in2 + 32'd1;
  assign fu_out2 = pipe2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run1(input int len, input bit use_last, input bit noise, input int exp_lat,
                      input logic [31:0] exp_first);
    int n, ce, ready_bad;
    logic [31:0] e;
    ready_bad = 0;
    for (int k = 0; k < len; k++) begin
      if (!in_ready) ready_bad++;
      in_valid = 1;
      in_data = ops[k];
      in_last = use_last && k == len - 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    in_last = 0;
    n = 1;
    ce = 0;
    while (!out_valid && n < 200) begin
      if (fu_ce) ce++;
      if (in_ready) ready_bad++;
      if (noise) begin
        in_valid = 1'($urandom);
        in_data = $urandom;
        in_last = 1'($urandom);
        done_ack = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    in_last = 0;
    done_ack = 0;
    chk("latency", 64'(n), 64'(exp_lat));
    chk("fu_ce_cycles", 64'(ce), 64'(exp_lat - 1));
    if (noise) begin
      in_valid = 1;
      in_last = 1;
      in_data = $urandom;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 0;
      in_last = 0;
    end
    chk("done_hold", {out_valid, in_ready, busy}, 3'b101);
    chk("ready_protocol", 64'(ready_bad), 0);
    chk("count", count, 64'(len));
    read_addr = 0;
    #1;
    chk("first_result", res, exp_first);
    for (int k = 0; k < len; k++) begin
      read_addr = 5'(k);
      #1;
      e = ops[k] + 32'd1;
      chk("result", res, e);
    end
    if (len < 32) begin
      read_addr = 5'(len);
      #1;
      chk("res_beyond_count", res, 0);
    end
    @(negedge clk);
    done_ack = 1;
    @(posedge clk); #1;
    done_ack = 0;
    chk("after_ack", {in_ready, out_valid, busy, count}, {1'b1, 1'b0, 1'b0, 6'd0});
    read_addr = 0;
    #1;
    chk("res_after_ack", res, 0);
  endtask

  task automatic run2(input int len, input bit use_last, input logic [31:0] base, input int exp_lat);
    int n;
    logic [31:0] e;
    for (int k = 0; k < len; k++) begin
      in_valid2 = 1;
      in_data2 = base + 32'(k);
      in_last2 = use_last && k == len - 1;
      @(posedge clk); #1;
    end
    in_valid2 = 0;
    in_last2 = 0;
    n = 1;
    while (!out_valid2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat1_latency", 64'(n), 64'(exp_lat));
    chk("lat1_count", count2, 64'(len));
    for (int k = 0; k < len; k++) begin
      read_addr2 = 2'(k);
      #1;
      e = base + 32'(k) + 32'd1;
      chk("lat1_result", res2, e);
    end
    @(negedge clk);
    done_ack2 = 1;
    @(posedge clk); #1;
    done_ack2 = 0;
    chk("lat1_ack", {in_ready2, out_valid2, count2}, {1'b1, 1'b0, 3'd0});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    logic [31:0] f;
    rst_n = 0;
    {in_valid, in_last, done_ack, in_data, read_addr} = '0;
    {in_valid2, in_last2, done_ack2, in_data2, read_addr2} = '0;
    #12;
    chk("reset_outputs", {in_ready, out_valid, busy, fu_ce, count, res}, {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0});
    chk("reset_outputs_lat1", {in_ready2, out_valid2, busy2, fu_ce2, count2}, {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    tbl = '{
      '{32, 32'd0,          1'b1, 1'b0, 63, 32'd1},
      '{5,  32'd10,         1'b1, 1'b0, 36, 32'd11},
      '{1,  32'hFFFF_FFFF,  1'b1, 1'b1, 32, 32'd0},
      '{32, 32'd100,        1'b0, 1'b1, 63, 32'd101},
      '{7,  32'h8000_0000,  1'b1, 1'b1, 38, 32'h8000_0001}
    };
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 32; k++) ops[k] = tbl[t].base + 32'(k);
      run1(tbl[t].len, tbl[t].use_last, tbl[t].noise, tbl[t].exp_lat, tbl[t].exp_first);
    end
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, 32));
      for (int k = 0; k < 32; k++) ops[k] = $urandom;
      f = ops[0] + 32'd1;
      run1(len, 1'b1, 1'b1, len + 31, f);
    end
    for (int k = 0; k < 32; k++) ops[k] = 32'h5000 + 32'(k);
    for (int k = 0; k < 32; k++) begin
      in_valid = 1;
      in_data = ops[k];
      in_last = k == 31;
      @(posedge clk); #1;
    end
    in_valid = 0;
    in_last = 0;
    repeat (42) @(posedge clk);
    #1;
    chk("pre_reset_drain", {busy, fu_ce, in_ready, out_valid}, 4'b1100);
    #2;
    rst_n = 0;
    read_addr = 0;
    #1;
    chk("async_reset_outputs", {in_ready, out_valid, busy, fu_ce, count, res}, {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0});
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) ops[k] = 32'hABC0 + 32'(k);
    run1(3, 1'b1, 1'b0, 34, 32'hABC1);
    run2(3, 1'b1, 32'd7, 5);
    run2(4, 1'b0, 32'd20, 6);
    run2(1, 1'b1, 32'hFFFF_FFFF, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
